issue_queue_ctrl: RTL and testbench

Dual-issue instruction queue and issue scheduler between fetch and the decode stage. Buffers up to two fetched instructions per cycle, and presents the oldest one or two instructions to decode as slot 1 and slot 2 each cycle. Pairs are split to single issue on intra-pair hazards or structural conflicts. Pops only the instructions decode actually accepts.

---
 rtl/issue_queue_ctrl.sv | 153 +++++++++++++++
 tb/tb_issue_queue_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : issue_queue_ctrl
// Purpose  : Dual-issue instruction queue and scheduler between fetch and
//            decode. Pairs split on intra-pair hazards or a shared mem port.
//            Optional feature macro: DUAL_ISSUE_EN (undefined = single issue).
// Revision : 1.0 - initial release
// ============================================================================
module issue_queue_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        stall,
    input  logic        fetch_valid1,
    input  logic        fetch_valid2,
    input  logic [31:0] fetch_addr1,
    input  logic [31:0] fetch_inst1,
    input  logic [31:0] fetch_addr2,
    input  logic [31:0] fetch_inst2,
    output logic        fetch_ready,
    input  logic        exe_mreg,
    input  logic [4:0]  exe_wa,
    output logic        issue_valid1,
    output logic        issue_valid2,
    output logic [31:0] iaddr1,
    output logic [31:0] inst1,
    output logic [31:0] iaddr2,
    output logic [31:0] inst2,
    output logic        issue_mode
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_READY_MAX = c_CW'(DEPTH - 2);
    localparam logic [c_CW-1:0] c_TWO       = c_CW'(2);

    logic [31:0]     r_mem_addr [DEPTH];
    logic [31:0]     r_mem_inst [DEPTH];
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_CW-1:0] r_count;

    logic [c_AW-1:0] w_rd_ptr2;
    logic [c_AW-1:0] w_wr_ptr2;
    logic [1:0]      w_push_cnt;
    logic [1:0]      w_pop_cnt;

    logic [5:0] w_op1, w_op2, w_func2;
    logic [4:0] w_rs1, w_rt1, w_rd1, w_rs2, w_rt2, w_rd2;
    logic [4:0] w_dest1, w_dest2;
    logic       w_lu1, w_lu2;
    logic       w_raw_waw, w_br2, w_mem_conflict;
    logic       w_dual_ok;

    function automatic logic [4:0] dest_of(input logic [5:0] op,
                                           input logic [4:0] rt,
                                           input logic [4:0] rd);
        if (op == 6'b000000)
            return rd;
        else if (op[5:3] == 3'b001 || op[5:3] == 3'b100)
            return rt;
        else if (op == 6'b000011)
            return 5'd31;
        else
            return 5'd0;
    endfunction

    function automatic logic is_branch(input logic [5:0] op,
                                       input logic [5:0] func);
        return (op >= 6'd1 && op <= 6'd7) ||
               (op == 6'd0 && (func == 6'b001000 || func == 6'b001001));
    endfunction

    assign w_rd_ptr2 = r_rd_ptr + c_AW'(1);
    assign w_wr_ptr2 = r_wr_ptr + c_AW'(1);

    // Slots are read straight from storage: no fetch-to-issue bypass.
    assign iaddr1 = r_mem_addr[r_rd_ptr];
    assign inst1  = r_mem_inst[r_rd_ptr];
    assign iaddr2 = r_mem_addr[w_rd_ptr2];
    assign inst2  = r_mem_inst[w_rd_ptr2];

    assign w_op1   = inst1[31:26];
    assign w_rs1   = inst1[25:21];
    assign w_rt1   = inst1[20:16];
    assign w_rd1   = inst1[15:11];
    assign w_op2   = inst2[31:26];
    assign w_rs2   = inst2[25:21];
    assign w_rt2   = inst2[20:16];
    assign w_rd2   = inst2[15:11];
    assign w_func2 = inst2[5:0];

    assign w_dest1 = dest_of(w_op1, w_rt1, w_rd1);
    assign w_dest2 = dest_of(w_op2, w_rt2, w_rd2);

    assign w_lu1 = exe_mreg && (exe_wa != 5'd0) &&
                   (exe_wa == w_rs1 || exe_wa == w_rt1);
    assign w_lu2 = exe_mreg && (exe_wa != 5'd0) &&
                   (exe_wa == w_rs2 || exe_wa == w_rt2);

    assign w_raw_waw = (w_dest1 != 5'd0) &&
                       (w_dest1 == w_rs2 || w_dest1 == w_rt2 || w_dest1 == w_dest2);
    assign w_br2          = is_branch(w_op2, w_func2);
    assign w_mem_conflict = w_op1[5] && w_op2[5];

`ifdef DUAL_ISSUE_EN
    assign w_dual_ok = !w_raw_waw && !w_br2 && !w_mem_conflict && !w_lu2;
`else
    // Hazard terms are still computed so the default build matches the
    // dual build's decode; they simply never enable slot 2.
    assign w_dual_ok = 1'b0 & w_raw_waw & w_br2 & w_mem_conflict & w_lu2;
`endif

    assign fetch_ready  = (r_count <= c_READY_MAX);
    assign issue_valid1 = !w_lu1 && (r_count != '0);
    assign issue_valid2 = issue_valid1 && (r_count >= c_TWO) && w_dual_ok;
    assign issue_mode   = issue_valid2;

    assign w_push_cnt = (fetch_ready && fetch_valid1) ? (fetch_valid2 ? 2'd2 : 2'd1) : 2'd0;
    assign w_pop_cnt  = stall ? 2'd0 : ({1'b0, issue_valid1} + {1'b0, issue_valid2});

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_addr[i] <= '0;
                r_mem_inst[i] <= '0;
            end
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_cnt != 2'd0) begin
                r_mem_addr[r_wr_ptr] <= fetch_addr1;
                r_mem_inst[r_wr_ptr] <= fetch_inst1;
            end
            if (w_push_cnt == 2'd2) begin
                r_mem_addr[w_wr_ptr2] <= fetch_addr2;
                r_mem_inst[w_wr_ptr2] <= fetch_inst2;
            end
            r_wr_ptr <= r_wr_ptr + c_AW'(w_push_cnt);
            r_rd_ptr <= r_rd_ptr + c_AW'(w_pop_cnt);
            r_count  <= r_count + c_CW'(w_push_cnt) - c_CW'(w_pop_cnt);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_issue_queue_ctrl.sv
`default_nettype none
// Scoreboard bench for issue_queue_ctrl: stimulus queues expected issues,
// a negedge monitor pops and compares whenever decode accepts a slot.
module tb_issue_queue_ctrl;

`ifdef DUAL_ISSUE_EN
    localparam bit c_DUAL = 1'b1;
`else
    localparam bit c_DUAL = 1'b0;
`endif

    localparam logic [31:0] c_ADDU_3_1_2 = 32'h0022_1821;
    localparam logic [31:0] c_ADDU_6_4_5 = 32'h0085_3021;
    localparam logic [31:0] c_ADDU_5_3_4 = 32'h0064_2821;
    localparam logic [31:0] c_LW_2_3     = 32'h8C62_0000;
    localparam logic [31:0] c_LW_4_5     = 32'h8CA4_0000;
    localparam logic [31:0] c_BEQ_7_8    = 32'h10E8_0000;

    logic        clk = 1'b0;
    logic        resetn, flush, stall;
    logic        fetch_valid1, fetch_valid2;
    logic [31:0] fetch_addr1, fetch_inst1, fetch_addr2, fetch_inst2;
    logic        fetch_ready;
    logic        exe_mreg;
    logic [4:0]  exe_wa;
    logic        issue_valid1, issue_valid2, issue_mode;
    logic [31:0] iaddr1, inst1, iaddr2, inst2;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        bit          dual;
    } exp_t;

    exp_t sb[$];
    exp_t e1, e2;
    int   errors = 0;
    int   checks = 0;

    issue_queue_ctrl #(.DEPTH(8)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .stall(stall),
        .fetch_valid1(fetch_valid1), .fetch_valid2(fetch_valid2),
        .fetch_addr1(fetch_addr1), .fetch_inst1(fetch_inst1),
        .fetch_addr2(fetch_addr2), .fetch_inst2(fetch_inst2),
        .fetch_ready(fetch_ready), .exe_mreg(exe_mreg), .exe_wa(exe_wa),
        .issue_valid1(issue_valid1), .issue_valid2(issue_valid2),
        .iaddr1(iaddr1), .inst1(inst1), .iaddr2(iaddr2), .inst2(inst2),
        .issue_mode(issue_mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Monitor: compare whatever decode accepts this cycle against the queue.
    always @(negedge clk) begin
        if (resetn && !flush && !stall && issue_valid1) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_issue (nothing expected)");
            end else begin
                e1 = sb.pop_front();
                chk("slot1_addr", iaddr1, e1.addr);
                chk("slot1_inst", inst1, e1.inst);
                chk("issue_mode", {31'b0, issue_mode}, {31'b0, e1.dual});
                chk("issue_valid2", {31'b0, issue_valid2}, {31'b0, e1.dual});
                if (e1.dual) begin
                    if (sb.size() == 0) begin
                        fail_now("slot2_missing_expectation");
                    end else begin
                        e2 = sb.pop_front();
                        chk("slot2_addr", iaddr2, e2.addr);
                        chk("slot2_inst", inst2, e2.inst);
                    end
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        fetch_valid1 = 1'b0;
        fetch_valid2 = 1'b0;
    endtask

    task automatic push1(input logic [31:0] a, input logic [31:0] i);
        fetch_valid1 = 1'b1; fetch_valid2 = 1'b0;
        fetch_addr1 = a; fetch_inst1 = i;
        sb.push_back('{addr: a, inst: i, dual: 1'b0});
    endtask

    // pair_dual: whether the pair is expected to dual-issue when dual is built in
    task automatic push2(input logic [31:0] a1, input logic [31:0] i1,
                         input logic [31:0] a2, input logic [31:0] i2,
                         input bit pair_dual);
        fetch_valid1 = 1'b1; fetch_valid2 = 1'b1;
        fetch_addr1 = a1; fetch_inst1 = i1;
        fetch_addr2 = a2; fetch_inst2 = i2;
        sb.push_back('{addr: a1, inst: i1, dual: pair_dual & c_DUAL});
        sb.push_back('{addr: a2, inst: i2, dual: 1'b0});
    endtask

    task automatic drain;
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            step;
            n++;
        end
        if (sb.size() != 0) begin
            fail_now("drain_timeout");
            sb.delete();
        end
        step;
        chk("empty_after_drain", {31'b0, issue_valid1}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; flush = 1'b0; stall = 1'b0; exe_mreg = 1'b0; exe_wa = 5'd0;
        fetch_addr1 = '0; fetch_inst1 = '0; fetch_addr2 = '0; fetch_inst2 = '0;
        idle();
        repeat (3) step;
        chk("rst_valid1", {31'b0, issue_valid1}, 32'd0);
        chk("rst_valid2", {31'b0, issue_valid2}, 32'd0);
        chk("rst_mode", {31'b0, issue_mode}, 32'd0);
        chk("rst_fetch_ready", {31'b0, fetch_ready}, 32'd1);
        chk("rst_iaddr1", iaddr1, 32'd0);
        chk("rst_inst2", inst2, 32'd0);
        resetn = 1'b1;
        step;

        // Independent pair, pushed into an empty queue: no bypass.
        push2(32'h100, c_ADDU_3_1_2, 32'h104, c_ADDU_6_4_5, 1'b1);
        #1;
        chk("no_bypass_valid1", {31'b0, issue_valid1}, 32'd0);
        step;
        idle();
        chk("pair_valid1", {31'b0, issue_valid1}, 32'd1);
        chk("pair_mode", {31'b0, issue_mode}, {31'b0, c_DUAL});
        drain();

        // RAW pair splits.
        push2(32'h100, c_ADDU_3_1_2, 32'h104, c_ADDU_5_3_4, 1'b0);
        step;
        idle();
        chk("raw_valid2", {31'b0, issue_valid2}, 32'd0);
        drain();

        // Branch in slot 2 splits; branch in slot 1 pairs with delay slot.
        push2(32'h300, c_ADDU_3_1_2, 32'h304, c_BEQ_7_8, 1'b0);
        step;
        push2(32'h310, c_BEQ_7_8, 32'h314, c_ADDU_6_4_5, 1'b1);
        step;
        idle();
        drain();

        // Two memory ops share one port.
        push2(32'h320, c_LW_2_3, 32'h324, c_LW_4_5, 1'b0);
        step;
        idle();
        drain();

        // Load-use on the head blocks issue.
        exe_mreg = 1'b1; exe_wa = 5'd3;
        push1(32'h400, c_LW_2_3);
        step;
        idle();
        chk("lu_valid1", {31'b0, issue_valid1}, 32'd0);
        chk("lu_valid2", {31'b0, issue_valid2}, 32'd0);
        step;
        chk("lu_hold_valid1", {31'b0, issue_valid1}, 32'd0);
        exe_mreg = 1'b0;
        #1;
        chk("lu_release_valid1", {31'b0, issue_valid1}, 32'd1);
        drain();

        // Fill to DEPTH-1 under stall, pointers wrap while draining.
        stall = 1'b1;
        push2(32'h500, 32'h0000_5021, 32'h504, 32'h0000_5821, 1'b1);
        step;
        push2(32'h508, 32'h0000_6021, 32'h50C, 32'h0000_6821, 1'b1);
        step;
        push2(32'h510, 32'h0000_7021, 32'h514, 32'h0000_7821, 1'b1);
        step;
        chk("fill6_fetch_ready", {31'b0, fetch_ready}, 32'd1);
        push1(32'h518, 32'h0000_8021);
        step;
        chk("full_fetch_ready", {31'b0, fetch_ready}, 32'd0);
        chk("stall_slot1_addr", iaddr1, 32'h500);
        fetch_valid1 = 1'b1; fetch_valid2 = 1'b1;
        fetch_addr1 = 32'hBAD0; fetch_addr2 = 32'hBAD4;
        step;
        idle();
        chk("full_hold_fetch_ready", {31'b0, fetch_ready}, 32'd0);
        chk("stall_hold_slot1_addr", iaddr1, 32'h500);
        stall = 1'b0;
        drain();

        // Flush during stall with a simultaneous push.
        stall = 1'b1;
        push2(32'h600, c_ADDU_3_1_2, 32'h604, c_ADDU_6_4_5, 1'b1);
        step;
        push2(32'h608, c_ADDU_3_1_2, 32'h60C, c_ADDU_6_4_5, 1'b1);
        step;
        push1(32'h610, c_ADDU_3_1_2);
        step;
        flush = 1'b1;
        fetch_valid1 = 1'b1; fetch_valid2 = 1'b1;
        fetch_addr1 = 32'h620; fetch_addr2 = 32'h624;
        sb.delete();
        step;
        flush = 1'b0;
        idle();
        chk("flush_valid1", {31'b0, issue_valid1}, 32'd0);
        chk("flush_valid2", {31'b0, issue_valid2}, 32'd0);
        chk("flush_fetch_ready", {31'b0, fetch_ready}, 32'd1);
        stall = 1'b0;
        repeat (3) step;
        chk("flush_stays_empty", {31'b0, issue_valid1}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
